// File: rtl/ifetch.sv
// ifetch: instruction fetch stage sitting behind the program counter.
//
// Fetches instruction bytes one at a time from memory over a req/ack
// handshake, buffers them with their addresses in a small prefetch FIFO and
// hands them to the decoder over valid/ready. A flush redirects fetch to a
// new PC and throws away everything buffered or still in flight.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset
//   pc        in   AW  redirect target, only looked at while flush=1
//   flush     in   1   redirect fetch to pc, discard stale bytes
//   mem_addr  out  AW  read address, held while mem_req=1 until mem_ack
//   mem_req   out  1   read request
//   mem_ack   in   1   single-cycle completion, mem_data valid with it
//   mem_data  in   DW  read data
//   ins       out  DW  byte at the head of the FIFO (0 when empty)
//   ins_addr  out  AW  address of ins (0 when empty)
//   ins_vld   out  1   FIFO non-empty
//   ins_rdy   in   1   decoder takes the head when ins_vld & ins_rdy
module ifetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          flush,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] ins,
  output logic [AW-1:0] ins_addr,
  output logic          ins_vld,
  input  logic          ins_rdy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // IDLE: no request. REQ: live request whose data is kept.
  // DROP: request issued before a flush; its data must be swallowed.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fptr_q, fptr_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] countAfterPop;
  logic          creditIdle;
  logic          creditPush;

  // Credit is judged on the occupancy after this cycle's pop, so a pop on a
  // full FIFO lets a new request go out in the same cycle.
  always_comb begin
    pop           = (count_q != '0) && ins_rdy;
    countAfterPop = count_q - CW'(pop);
    creditIdle    = countAfterPop < CW'(DEPTH);
    creditPush    = (countAfterPop + CW'(1)) < CW'(DEPTH);
  end

  // Fetch control: decides the next request address and whether the ack
  // arriving this cycle is kept or discarded.
  always_comb begin
    state_d = state_q;
    fptr_d  = fptr_q;
    maddr_d = maddr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          fptr_d  = pc;
          maddr_d = pc;
          state_d = REQ;
        end else if (creditIdle) begin
          maddr_d = fptr_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (flush) begin
            fptr_d  = pc;
            maddr_d = pc;
          end else begin
            push   = 1'b1;
            fptr_d = fptr_q + AW'(1);
            if (creditPush) begin
              maddr_d = fptr_q + AW'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end else if (flush) begin
          // The handshake cannot be withdrawn; finish it in DROP.
          fptr_d  = pc;
          state_d = DROP;
        end
      end
      DROP: begin
        if (flush) begin
          fptr_d = pc;
        end
        if (mem_ack) begin
          maddr_d = fptr_d;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer/occupancy bookkeeping; a flush empties it outright.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fptr_q  <= '0;
      maddr_q <= '0;
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      fptr_q  <= fptr_d;
      maddr_q <= maddr_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end

  // FIFO storage needs no reset: the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      data_q[wptr_q] <= mem_data;
      addr_q[wptr_q] <= maddr_q;
    end
  end

  assign mem_req  = (state_q != IDLE);
  assign mem_addr = maddr_q;
  assign ins_vld  = (count_q != '0);
  assign ins      = ins_vld ? data_q[rptr_q] : '0;
  assign ins_addr = ins_vld ? addr_q[rptr_q] : '0;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch.
//
// A memory responder acks requests after a programmable or random delay.
// A reference model holds the prefetch buffer as a queue plus a record of
// the outstanding request (address, and whether a redirect has made it
// stale). Every cycle the DUT outputs are compared against it, and directed
// scenarios pin the behaviour with hand-computed literal values.
module tb_ifetch;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        flush;
  logic [15:0] memAddr;
  logic        memReq;
  logic        memAck;
  logic [7:0]  memData;
  logic [7:0]  ins;
  logic [15:0] insAddr;
  logic        insVld;
  logic        insRdy;

  ifetch #(.DEPTH(DEPTH), .AW(16), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .flush    (flush),
    .mem_addr (memAddr),
    .mem_req  (memReq),
    .mem_ack  (memAck),
    .mem_data (memData),
    .ins      (ins),
    .ins_addr (insAddr),
    .ins_vld  (insVld),
    .ins_rdy  (insRdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Memory responder knobs.
  int ackDelay = 0;
  int curDelay = 0;
  int waitCnt = 0;
  bit randDelay = 0;
  bit forceAck = 0;
  bit dataIsAddr = 1;

  // Observation logs (DUT values, compared to literals in directed tests).
  logic [15:0] ackLog[$];
  logic [15:0] popAddrLog[$];
  logic [7:0]  popDataLog[$];

  // Reference model state.
  logic [15:0] mqAddr[$];
  logic [7:0]  mqData[$];
  logic [15:0] mFptr;
  bit          mReqOn;
  logic [15:0] mReqAddr;
  bit          mStale;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] logAddrAt(int i);
    if (i < popAddrLog.size()) return popAddrLog[i];
    return 16'hDEAD;
  endfunction

  function automatic logic [7:0] logDataAt(int i);
    if (i < popDataLog.size()) return popDataLog[i];
    return 8'hEE;
  endfunction

  // Advance the reference model by one clock, from the inputs now driven.
  task automatic modelUpdate();
    bit doPop;
    bit accept;
    if (rst) begin
      mqAddr.delete();
      mqData.delete();
      mFptr = 16'h0000;
      mReqOn = 0;
      mReqAddr = 16'h0000;
      mStale = 0;
      return;
    end
    doPop = (mqAddr.size() > 0) && insRdy;
    accept = mReqOn && memAck && !mStale && !flush;
    if (flush) begin
      mqAddr.delete();
      mqData.delete();
    end else begin
      if (doPop) begin
        void'(mqAddr.pop_front());
        void'(mqData.pop_front());
      end
      if (accept) begin
        mqAddr.push_back(mReqAddr);
        mqData.push_back(memData);
      end
    end
    if (!mReqOn) begin
      if (flush) begin
        mFptr = pc;
        mReqOn = 1;
        mReqAddr = pc;
      end else if (mqAddr.size() < DEPTH) begin
        mReqOn = 1;
        mReqAddr = mFptr;
      end
    end else if (memAck) begin
      if (mStale) begin
        if (flush) mFptr = pc;
        mReqAddr = mFptr;
        mStale = 0;
      end else if (flush) begin
        mFptr = pc;
        mReqAddr = pc;
      end else begin
        mFptr = mFptr + 16'd1;
        if (mqAddr.size() < DEPTH) mReqAddr = mFptr;
        else mReqOn = 0;
      end
    end else if (flush) begin
      mFptr = pc;
      mStale = 1;
    end
  endtask

  // Compare every meaningful DUT output against the model.
  task automatic checkOutput();
    check("mem_req", 32'(memReq), 32'(mReqOn));
    if (mReqOn) check("mem_addr", 32'(memAddr), 32'(mReqAddr));
    check("ins_vld", 32'(insVld), 32'(mqAddr.size() != 0));
    if (mqAddr.size() != 0) begin
      check("ins", 32'(ins), 32'(mqData[0]));
      check("ins_addr", 32'(insAddr), 32'(mqAddr[0]));
    end
  endtask

  // One cycle: respond to memory, log handshakes, step model, clock, check.
  task automatic applyStimulus();
    int dly;
    dly = randDelay ? curDelay : ackDelay;
    if (rst || !memReq) begin
      memAck = 1'b0;
      waitCnt = 0;
    end else if (forceAck || waitCnt >= dly) begin
      memAck = 1'b1;
      memData = dataIsAddr ? memAddr[7:0] : 8'($urandom);
      ackLog.push_back(memAddr);
      waitCnt = 0;
      curDelay = $urandom_range(0, 3);
    end else begin
      memAck = 1'b0;
      waitCnt++;
    end
    if (insVld && insRdy && !rst) begin
      popAddrLog.push_back(insAddr);
      popDataLog.push_back(ins);
    end
    modelUpdate();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runCycles(int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic doReset();
    rst = 1'b1;
    flush = 1'b0;
    forceAck = 0;
    randDelay = 0;
    dataIsAddr = 1;
    runCycles(2);
    rst = 1'b0;
    ackLog.delete();
    popAddrLog.delete();
    popDataLog.delete();
  endtask

  initial begin
    rst = 1'b1;
    pc = 16'h0000;
    flush = 1'b0;
    memAck = 1'b0;
    memData = 8'h00;
    insRdy = 1'b1;
    mFptr = 16'h0000;
    mReqOn = 0;
    mReqAddr = 16'h0000;
    mStale = 0;
    @(negedge clk);

    // Scenario 1: streaming with one-cycle memory latency.
    doReset();
    check("rst_mem_req", 32'(memReq), 32'h0);
    check("rst_ins_vld", 32'(insVld), 32'h0);
    check("rst_ins", 32'(ins), 32'h0);
    check("rst_ins_addr", 32'(insAddr), 32'h0);
    ackDelay = 1;
    insRdy = 1'b1;
    runCycles(14);
    check("s1_first_req_addr", 32'(ackLog.size() > 0 ? ackLog[0] : 16'hDEAD), 32'h0000);
    check("s1_pop_count_ge4", 32'(popAddrLog.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("s1_ins_addr", 32'(logAddrAt(i)), i);
      check("s1_ins", 32'(logDataAt(i)), i);
    end

    // Scenario 2: decoder stalled, FIFO fills to exactly DEPTH.
    doReset();
    ackDelay = 0;
    insRdy = 1'b0;
    runCycles(10);
    check("s2_push_count", ackLog.size(), 4);
    check("s2_mem_req_low", 32'(memReq), 32'h0);
    check("s2_ins_vld", 32'(insVld), 32'h1);
    check("s2_ins_head", 32'(ins), 32'h00);
    check("s2_model_depth", mqAddr.size(), 4);
    insRdy = 1'b1;
    applyStimulus();
    insRdy = 1'b0;
    runCycles(6);
    check("s2_refill_count", ackLog.size(), 5);
    check("s2_refill_addr", 32'(ackLog.size() > 4 ? ackLog[4] : 16'hDEAD), 32'h0004);
    check("s2_new_head", 32'(ins), 32'h01);

    // Scenario 3: flush while a request is pending, ack three cycles later.
    doReset();
    ackDelay = 1000;
    insRdy = 1'b1;
    flush = 1'b1;
    pc = 16'h0005;
    applyStimulus();
    flush = 1'b0;
    check("s3_req_addr5", 32'(memAddr), 32'h0005);
    flush = 1'b1;
    pc = 16'h1234;
    applyStimulus();
    flush = 1'b0;
    check("s3_hold_addr_a", 32'(memAddr), 32'h0005);
    check("s3_ins_vld_a", 32'(insVld), 32'h0);
    applyStimulus();
    check("s3_hold_addr_b", 32'(memAddr), 32'h0005);
    forceAck = 1;
    applyStimulus();
    forceAck = 0;
    check("s3_redirect_addr", 32'(memAddr), 32'h1234);
    check("s3_model_redirect", 32'(mReqAddr), 32'h1234);
    check("s3_req_high", 32'(memReq), 32'h1);
    check("s3_ins_vld_b", 32'(insVld), 32'h0);
    ackDelay = 0;
    insRdy = 1'b0;
    applyStimulus();
    check("s3_first_ins_addr", 32'(insAddr), 32'h1234);
    check("s3_first_ins", 32'(ins), 32'h34);

    // Scenario 4: flush in the same cycle as an ack.
    doReset();
    ackDelay = 1000;
    insRdy = 1'b0;
    flush = 1'b1;
    pc = 16'h0007;
    applyStimulus();
    forceAck = 1;
    pc = 16'h0040;
    applyStimulus();
    forceAck = 0;
    flush = 1'b0;
    check("s4_redirect_addr", 32'(memAddr), 32'h0040);
    check("s4_ins_vld", 32'(insVld), 32'h0);
    ackDelay = 0;
    applyStimulus();
    check("s4_first_ins_addr", 32'(insAddr), 32'h0040);
    check("s4_first_ins", 32'(ins), 32'h40);

    // Scenario 5: address wrap at the top of memory.
    doReset();
    ackDelay = 0;
    insRdy = 1'b1;
    flush = 1'b1;
    pc = 16'hFFFE;
    applyStimulus();
    flush = 1'b0;
    popAddrLog.delete();
    popDataLog.delete();
    runCycles(8);
    check("s5_wrap_0", 32'(logAddrAt(0)), 32'hFFFE);
    check("s5_wrap_1", 32'(logAddrAt(1)), 32'hFFFF);
    check("s5_wrap_2", 32'(logAddrAt(2)), 32'h0000);

    // Scenario 6: reset with two buffered bytes and a request pending.
    doReset();
    ackDelay = 1000;
    insRdy = 1'b0;
    flush = 1'b1;
    pc = 16'h0100;
    applyStimulus();
    flush = 1'b0;
    ackDelay = 0;
    runCycles(2);
    ackDelay = 1000;
    check("s6_pending_addr", 32'(memAddr), 32'h0102);
    check("s6_buffered", 32'(insVld), 32'h1);
    rst = 1'b1;
    applyStimulus();
    check("s6_rst_req", 32'(memReq), 32'h0);
    check("s6_rst_vld", 32'(insVld), 32'h0);
    rst = 1'b0;
    ackDelay = 1;
    applyStimulus();
    check("s6_first_req", 32'(memReq), 32'h1);
    check("s6_first_addr", 32'(memAddr), 32'h0000);

    // Randomized traffic against the model.
    doReset();
    randDelay = 1;
    dataIsAddr = 0;
    curDelay = $urandom_range(0, 3);
    for (int i = 0; i < 3000; i++) begin
      bit stallBias;
      stallBias = ((i / 400) % 2) == 1;
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) pc = 16'hFFFC + 16'($urandom_range(0, 3));
      else pc = 16'($urandom);
      insRdy = stallBias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
